// File: rtl/binary_to_onehot.sv
// binary_to_onehot: registered binary-index to one-hot decoder.
// The result is captured one clock after an accepted index. out_valid flags
// the cycle immediately after each accepted index. clear zeroes the output
// and takes priority over in_valid.
//
// Handshake: an index is accepted on any rising edge where in_valid is high
// and clear is low. There is no ready signal; the block takes one index per
// clock with no stall. binary_input is a don't-care while in_valid is low.
module binary_to_onehot #(
    parameter int input_width = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [input_width-1:0]        binary_input,
    input  logic                          in_valid,
    input  logic                          clear,
    output logic [(1 << input_width)-1:0] onehot_output,
    output logic                          out_valid
);

    localparam int OutWidth = 1 << input_width;

    logic [OutWidth-1:0] onehot_dec;
    logic [OutWidth-1:0] onehot_d;
    logic [OutWidth-1:0] onehot_q;
    logic                valid_d;
    logic                valid_q;

    // Decode the index.
    // Every index value selects exactly one output line, so no out-of-range case exists.
    always_comb begin
        onehot_dec = '0;
        for (int k = 0; k < OutWidth; k++) begin
            onehot_dec[k] = (binary_input == input_width'(k));
        end
    end

    // Next-state logic: clear wins, otherwise capture on in_valid, otherwise hold.
    always_comb begin
        onehot_d = onehot_q;
        valid_d  = 1'b0;
        if (clear) begin
            onehot_d = '0;
        end else if (in_valid) begin
            onehot_d = onehot_dec;
            valid_d  = 1'b1;
        end
    end

    // Output registers.
    // Asynchronous reset drops any in-flight decode immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
        end
    end

    assign onehot_output = onehot_q;
    assign out_valid     = valid_q;

endmodule

// File: tb/tb_binary_to_onehot.sv
// Testbench for binary_to_onehot.
// Uses a 4-bit instance for the main checks and a 2-bit instance for the parameter check.
module tb_binary_to_onehot;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (input_width = 4) ----------------
  logic [3:0]  bin;
  logic        vld;
  logic        clr;
  logic [15:0] oh;
  logic        ov;

  binary_to_onehot #(.input_width(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .binary_input  (bin),
    .in_valid      (vld),
    .clear         (clr),
    .onehot_output (oh),
    .out_valid     (ov)
  );

  // ---------------- DUT (input_width = 2) ----------------
  logic [1:0] bin2;
  logic       vld2;
  logic       clr2;
  logic [3:0] oh2;
  logic       ov2;

  binary_to_onehot #(.input_width(2)) dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .binary_input  (bin2),
    .in_valid      (vld2),
    .clear         (clr2),
    .onehot_output (oh2),
    .out_valid     (ov2)
  );

  // ---------------- scoreboard ----------------
  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [16:0] exp_q[$];   // {out_valid, onehot_output}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  typedef struct {
    logic [3:0]  bin;
    logic        vld;
    logic        clr;
    logic [15:0] exp_oh;
    logic        exp_v;
  } vec_t;

  vec_t vecs[24];

  // Drive one cycle of inputs and queue the expected result.
  // Pop and compare the result one edge later.
  task automatic step(input vec_t v, input string name);
    logic [16:0] e;
    bin = v.bin;
    vld = v.vld;
    clr = v.clr;
    exp_q.push_back({v.exp_v, v.exp_oh});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({name, "_oh"}, 32'(oh), 32'(e[15:0]));
    check({name, "_valid"}, 32'(ov), 32'(e[16]));
    if (ov === 1'b1) check({name, "_popcount"}, 32'($countones(oh)), 32'd1);
  endtask

  logic [3:0] exp2 [4];

  initial begin
    bin = 4'h5; vld = 1'b1; clr = 1'b0;
    bin2 = 2'd0; vld2 = 1'b0; clr2 = 1'b0;

    // ---- reset held with valid input and clocks running ----
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("reset_oh", 32'(oh), 32'h0);
      check("reset_valid", 32'(ov), 32'h0);
    end
    check("reset_oh_w2", 32'(oh2), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_oh", 32'(oh), 32'h0020);
    check("post_reset_valid", 32'(ov), 32'h1);

    // ---- vector table ----
    // Full sweep 0..15 then wrap to 0.
    for (int i = 0; i < 17; i++) begin
      vecs[i].bin    = 4'(i);
      vecs[i].vld    = 1'b1;
      vecs[i].clr    = 1'b0;
      vecs[i].exp_oh = 16'h1 << (i % 16);
      vecs[i].exp_v  = 1'b1;
    end
    // hold: index 9, then three idle cycles with changing garbage index
    vecs[17] = '{bin: 4'h9, vld: 1'b1, clr: 1'b0, exp_oh: 16'h0200, exp_v: 1'b1};
    for (int i = 18; i < 21; i++)
      vecs[i] = '{bin: 4'($urandom_range(0, 15)), vld: 1'b0, clr: 1'b0,
                  exp_oh: 16'h0200, exp_v: 1'b0};
    // clear has priority over in_valid
    vecs[21] = '{bin: 4'h3, vld: 1'b1, clr: 1'b1, exp_oh: 16'h0000, exp_v: 1'b0};
    // idle after clear keeps zero
    vecs[22] = '{bin: 4'hA, vld: 1'b0, clr: 1'b0, exp_oh: 16'h0000, exp_v: 1'b0};
    // top index after clear
    vecs[23] = '{bin: 4'hF, vld: 1'b1, clr: 1'b0, exp_oh: 16'h8000, exp_v: 1'b1};

    for (int i = 0; i < 24; i++) step(vecs[i], $sformatf("vec%0d", i));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // ---- asynchronous reset mid-stream ----
    bin = 4'h7; vld = 1'b1; clr = 1'b0;
    @(posedge clk);
    #1;
    check("stream_oh", 32'(oh), 32'h0080);
    #2;
    rst_n = 1'b0;   // between edges
    #1;
    check("async_rst_oh", 32'(oh), 32'h0);
    check("async_rst_valid", 32'(ov), 32'h0);
    @(posedge clk);
    #1;
    check("async_rst_hold_oh", 32'(oh), 32'h0);
    vld = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_rst_idle_oh", 32'(oh), 32'h0);
    check("after_rst_idle_valid", 32'(ov), 32'h0);

    // ---- parameter check: input_width = 2 ----
    exp2[0] = 4'b0001; exp2[1] = 4'b0010; exp2[2] = 4'b0100; exp2[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      bin2 = 2'(i);
      vld2 = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("w2_idx%0d_oh", i), 32'(oh2), 32'(exp2[i]));
      check($sformatf("w2_idx%0d_valid", i), 32'(ov2), 32'h1);
    end
    vld2 = 1'b0;
    @(posedge clk);
    #1;
    check("w2_hold_oh", 32'(oh2), 32'(exp2[3]));
    check("w2_hold_valid", 32'(ov2), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
